trace_sequencer: RTL
====================

Name: trace_sequencer

Overview:
- Source end of the trace/cache handshake: stores a list of 32-bit memory addresses and replays them one at a time into the cache simulator top.
- Per address: drives `mem_addr`, pulses `trace_ready`, then waits for the cache's `update_lru` acknowledge before issuing the next address.
- Also counts issued accesses and elapsed cycles, and flags a hung cache through a watchdog.
- Replaces the hard-wired trace source in front of the cache simulator.

Parameters:
- `DEPTH`, 1024, maximum number of trace entries (power of 2).
- `ADDR_W`, 32, width of a trace address.
- `GAP_CYCLES`, 1, idle cycles inserted after each acknowledge before the next fetch (0 allowed).
- `TIMEOUT`, 4095, maximum cycles allowed from `trace_ready` to `update_lru` before abort.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `clear`  in  1  pulse; empties trace store (write pointer := 0). Ignored while `busy`.
- `wr_en`  in  1  append `wr_data` to trace store.
- `wr_data`  in  ADDR_W  trace address to append.
- `full`  out  1  store holds DEPTH entries.
- `start`  in  1  pulse; begin replay from entry 0.
- `update_lru`  in  1  cache acknowledge: current access finished.
- `mem_addr`  out  ADDR_W  address presented to the cache.
- `trace_ready`  out  1  one-cycle pulse: `mem_addr` is a new valid access.
- `busy`  out  1  replay in progress.
- `done`  out  1  one-cycle pulse at replay end (normal or abort).
- `timeout_err`  out  1  sticky; set on watchdog expiry, cleared by `start` or reset.
- `issued_count`  out  32  accesses acknowledged in current replay.
- `total_cycles`  out  32  cycles from `start` accept to `done`.

Behaviour:
- Reset values: all outputs 0, except `full` = 0; `mem_addr` = 0; write pointer 0; state IDLE.
- Trace store contents are not reset.
- Writes:
  - Accepted only in IDLE with !full; entry [wr_ptr] := `wr_data`, wr_ptr++.
  - `wr_en` while busy or full is dropped silently.
  - `clear` and `wr_en` in the same cycle: `clear` wins.
- States: IDLE, FETCH, ISSUE, WAIT, GAP, FIN.
- IDLE:
  - `start` → clears `issued_count`, `total_cycles`, `timeout_err`; rd_ptr := 0.
  - If wr_ptr == 0, go to FIN; else go to FETCH.
  - `busy` = 1 in every state except IDLE.
- FETCH: one cycle for the synchronous store read at rd_ptr → ISSUE.
- ISSUE (1 cycle): load `mem_addr` from read data; `trace_ready` = 1 this cycle only; watchdog := 0 → WAIT.
  - `mem_addr` is held stable from ISSUE until the next ISSUE.
- WAIT: watchdog increments each cycle.
  - On `update_lru`: `issued_count`++, rd_ptr++. Go to FIN if rd_ptr+1 == wr_ptr; else GAP, or FETCH when GAP_CYCLES == 0.
  - If watchdog reaches TIMEOUT with no ack: `timeout_err` := 1 → FIN.
  - If ack and timeout occur in the same cycle, the ack wins.
- `update_lru` outside WAIT (including the ISSUE cycle) is ignored and not counted.
- GAP: counts GAP_CYCLES cycles → FETCH.
- FIN: `done` = 1 for one cycle → IDLE.
- `total_cycles` increments every cycle while busy, including the FIN cycle; it saturates at 0xFFFFFFFF.
- Latency:
  - `start` at cycle 0 → `trace_ready` at cycle 2.
  - Ack at cycle k → next `trace_ready` at k + 2 + GAP_CYCLES.
- `start` while busy is ignored.
- Reset mid-replay: immediate return to IDLE with all outputs at reset values; wr_ptr := 0.
- Pointers are log2(DEPTH)+1 bits wide; `full` = (wr_ptr == DEPTH). No wrap: writes stop at DEPTH.

Decomposition:
- Package `trace_pkg`:
  - state enum `trace_state_t`;
  - `localparam PTR_W = $clog2(DEPTH)+1`;
  - watchdog width `WD_W = $clog2(TIMEOUT+1)`.
- Sub-module `trace_ram`: simple dual-port synchronous RAM, DEPTH x ADDR_W, one write port and one registered read port. The sequencer FSM, counters and watchdog stay in `trace_sequencer`.

Test Plan:
- Basic replay:
  - Stimulus: write 0x0000_0010, 0x0000_0020, 0x0000_0030; `start`; cache model acks 3 cycles after each `trace_ready`.
  - Required: three `trace_ready` pulses with `mem_addr` 0x10/0x20/0x30 in order; `issued_count` = 3; `done` pulse; `timeout_err` = 0.
- Latency:
  - Stimulus: GAP_CYCLES = 0; `start` at cycle 0; ack 1 cycle after each pulse.
  - Required: `trace_ready` at cycles 2 and 5; `done` at cycle 7; `total_cycles` = 7.
- Empty store:
  - Stimulus: `start` with wr_ptr = 0.
  - Required: `done` at cycle 1; `issued_count` = 0; no `trace_ready`.
- Watchdog:
  - Stimulus: TIMEOUT = 8; cache never acks.
  - Required: `timeout_err` = 1 and `done` 9 cycles after `trace_ready`; `issued_count` = 0. A following `start` clears `timeout_err`.
- Boundary:
  - Stimulus: DEPTH = 4; write 5 entries, then `start` and replay.
  - Required: `full` = 1 after the 4th write; the 5th write is dropped; replay issues exactly 4 addresses.
- Spurious ack and reset:
  - Stimulus: pulse `update_lru` in IDLE and in the ISSUE cycle; later assert `rst_n` = 0 during WAIT.
  - Required: spurious acks are not counted; after reset `busy` = 0, `mem_addr` = 0, and a subsequent `start` completes immediately (store empty).

Source files
------------

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared state encoding and width helpers for the trace sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_FIN   = 3'd5
    } trace_state_t;

    localparam int DEFAULT_DEPTH   = 1024;
    localparam int DEFAULT_TIMEOUT = 4095;
    localparam int PTR_W           = $clog2(DEFAULT_DEPTH) + 1;
    localparam int WD_W            = $clog2(DEFAULT_TIMEOUT + 1);

    // Pointers carry one extra bit so that "DEPTH entries stored" is representable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic int gap_width(input int gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : trace_ram
// Description : DEPTH x ADDR_W trace store, one write port, registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = ptr_width(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [ADDR_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [ADDR_W-1:0] o_rd_data
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_idx];
    end

endmodule
`default_nettype wire

// File: rtl/trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trace_sequencer
// Description : Replays stored trace addresses into the cache, one per ack,
//               with access/cycle counters and a hung-cache watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_sequencer
    import trace_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 32,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_data,
    output logic              full,
    input  logic              start,
    input  logic              update_lru,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              trace_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [31:0]       issued_count,
    output logic [31:0]       total_cycles
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_IDX_W = c_PTR_W - 1;
    localparam int c_WD_W  = wd_width(TIMEOUT);
    localparam int c_GAP_W = gap_width(GAP_CYCLES);

    localparam logic [c_PTR_W-1:0] c_PTR_FULL = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    trace_state_t       r_state;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_WD_W-1:0]  r_wd;
    logic [c_GAP_W-1:0] r_gap;

    logic [ADDR_W-1:0]  w_rd_data;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_ack;
    logic               w_last;
    logic               w_wr_accept;

    assign full        = (r_wr_ptr == c_PTR_FULL);
    assign w_ack       = (r_state == ST_WAIT) && update_lru;
    assign w_last      = ((r_rd_ptr + c_PTR_ONE) == r_wr_ptr);
    assign w_wr_accept = (r_state == ST_IDLE) && wr_en && !clear && !full;

    // Read one cycle ahead of FETCH so read data is ready when mem_addr loads.
    always_comb begin
        w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
        if (r_state == ST_IDLE) begin
            w_rd_idx = '0;
        end else if (w_ack) begin
            w_rd_idx = r_rd_ptr[c_IDX_W-1:0] + c_IDX_W'(1);
        end
    end

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_idx  (r_wr_ptr[c_IDX_W-1:0]),
        .i_wr_data (wr_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wd         <= '0;
            r_gap        <= '0;
            mem_addr     <= '0;
            trace_ready  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            issued_count <= '0;
            total_cycles <= '0;
        end else begin
            trace_ready <= 1'b0;
            done        <= 1'b0;
            if ((r_state != ST_IDLE) && (total_cycles != '1)) begin
                total_cycles <= total_cycles + 32'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (clear) begin
                        r_wr_ptr <= '0;
                    end else if (w_wr_accept) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                    end
                    if (start) begin
                        issued_count <= '0;
                        total_cycles <= '0;
                        timeout_err  <= 1'b0;
                        r_rd_ptr     <= '0;
                        busy         <= 1'b1;
                        if (r_wr_ptr == '0) begin
                            r_state <= ST_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    mem_addr    <= w_rd_data;
                    trace_ready <= 1'b1;
                    r_wd        <= '0;
                    r_state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // Ack is tested first so it wins over a coincident timeout.
                    if (update_lru) begin
                        issued_count <= issued_count + 32'd1;
                        r_rd_ptr     <= r_rd_ptr + c_PTR_ONE;
                        r_gap        <= '0;
                        if (w_last) begin
                            r_state <= ST_FIN;
                            done    <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            r_state <= ST_FETCH;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else if (r_wd == c_WD_LAST) begin
                        timeout_err <= 1'b1;
                        r_state     <= ST_FIN;
                        done        <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                ST_FIN: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
